// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard that picks regfile read, forward or stall
// for each decode source operand. Forwarding path is enabled by defining HAZARD_FWD_EN.
module hazard_scoreboard #(
  parameter int REG_W     = 5,
  parameter int NSRC      = 2,
  parameter int LAT_W     = 3,
  parameter int FWD_DEPTH = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    issue_valid,
  input  logic                    issue_kill,
  input  logic [REG_W-1:0]        issue_wsel,
  input  logic [LAT_W-1:0]        issue_lat,
  input  logic [NSRC*REG_W-1:0]   rsel,
  input  logic [NSRC-1:0]         rvalid,
  output logic                    stall,
  output logic [NSRC*LAT_W-1:0]   fwd_sel,
  output logic [15:0]             stall_cnt
);

  localparam int NREGS = 2**REG_W;

`ifdef HAZARD_FWD_EN
  localparam int FWD_LIM = FWD_DEPTH;
`else
  // Without forwarding every pending result stalls; FWD_DEPTH has no effect.
  localparam int FWD_LIM = 0 * FWD_DEPTH;
`endif

  logic [LAT_W-1:0] pend [NREGS];
  logic [LAT_W-1:0] src_cnt;
  logic [NSRC-1:0]  raw_hit;
  logic             waw_hit;
  logic             issue_fire;

  // Counts above FWD_LIM stall; fwd_sel shows the count clamped to FWD_LIM.
  always_comb begin
    raw_hit = '0;
    fwd_sel = '0;
    src_cnt = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_cnt = pend[rsel[i*REG_W +: REG_W]];
      if (rvalid[i] && (rsel[i*REG_W +: REG_W] != '0)) begin
        if (int'(src_cnt) > FWD_LIM) begin
          raw_hit[i]                 = 1'b1;
          fwd_sel[i*LAT_W +: LAT_W]  = LAT_W'(FWD_LIM);
        end else begin
          fwd_sel[i*LAT_W +: LAT_W]  = src_cnt;
        end
      end
    end
  end

  // A zero latency is a no-write, so it neither loads nor raises a WAW hazard.
  assign waw_hit    = issue_valid && !issue_kill && (issue_wsel != '0) &&
                      (issue_lat != '0) && (issue_lat <= pend[issue_wsel]);
  assign stall      = (|raw_hit) | waw_hit;
  assign issue_fire = issue_valid && !issue_kill && !stall &&
                      (issue_wsel != '0) && (issue_lat != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) pend[r] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (r == 0)
          pend[r] <= '0;
        else if (issue_fire && (issue_wsel == REG_W'(r)))
          pend[r] <= issue_lat;
        else if (pend[r] != '0)
          pend[r] <= pend[r] - LAT_W'(1);
      end
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios then random traffic,
// compared against a cycles-remaining reference model. Honours HAZARD_FWD_EN.
module tb_hazard_scoreboard;

`ifdef HAZARD_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif
  localparam int FD = 2;

  logic        CLK;
  logic        RST;
  logic        issue_valid;
  logic        issue_kill;
  logic [4:0]  issue_wsel;
  logic [2:0]  issue_lat;
  logic [9:0]  rsel;
  logic [1:0]  rvalid;
  logic        stall;
  logic [5:0]  fwd_sel;
  logic [15:0] stall_cnt;

  int pm [32];
  int cnt_m;
  int checks;
  int errors;
  int base;

  hazard_scoreboard #(.REG_W(5), .NSRC(2), .LAT_W(3), .FWD_DEPTH(FD)) dut (
    .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_kill(issue_kill),
    .issue_wsel(issue_wsel), .issue_lat(issue_lat), .rsel(rsel), .rvalid(rvalid),
    .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One decode cycle: drive, predict, check at negedge, then advance the model at posedge.
  task automatic step(input bit r, input bit v, input bit k, input int w, input int l,
                      input int s0, input int s1, input bit [1:0] rv);
    int srcs [2];
    int exp_f [2];
    bit exp_s;
    int c;
    RST = r; issue_valid = v; issue_kill = k;
    issue_wsel = 5'(w); issue_lat = 3'(l);
    rsel = {5'(s1), 5'(s0)}; rvalid = rv;
    srcs[0] = s0; srcs[1] = s1;
    exp_s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_f[i] = 0;
      if (rv[i] && srcs[i] != 0) begin
        c = pm[srcs[i]];
        if (c > 0) begin
          if (FWD_ON && c <= FD) exp_f[i] = c;
          else exp_s = 1'b1;
        end
      end
    end
    if (v && !k && w != 0 && l != 0 && l <= pm[w]) exp_s = 1'b1;
    @(negedge CLK);
    checks++;
    assert (stall === exp_s) else begin
      errors++;
      $error("FAIL stall: observed %0b expected %0b at %0t", stall, exp_s, $time);
    end
    if (!exp_s) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        assert (fwd_sel[i*3 +: 3] === 3'(exp_f[i])) else begin
          errors++;
          $error("FAIL fwd_sel[%0d]: observed %0d expected %0d at %0t", i, fwd_sel[i*3 +: 3], exp_f[i], $time);
        end
      end
    end
    checks++;
    assert (stall_cnt === 16'(cnt_m)) else begin
      errors++;
      $error("FAIL stall_cnt: observed %0d expected %0d at %0t", stall_cnt, cnt_m, $time);
    end
    @(posedge CLK);
    if (r) begin
      for (int q = 0; q < 32; q++) pm[q] = 0;
      cnt_m = 0;
    end else begin
      if (exp_s && cnt_m < 65535) cnt_m++;
      for (int q = 1; q < 32; q++) if (pm[q] > 0) pm[q]--;
      if (v && !k && !exp_s && w != 0 && l != 0) pm[w] = l;
    end
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; cnt_m = 0;
    for (int q = 0; q < 32; q++) pm[q] = 0;

    // Reset held two cycles while an issue is presented; the issue must be ignored.
    RST = 1'b1; issue_valid = 1'b1; issue_kill = 1'b0;
    issue_wsel = 5'd5; issue_lat = 3'd3; rsel = '0; rvalid = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0; issue_valid = 1'b0; rsel = {5'd5, 5'd5}; rvalid = 2'b11;
    @(negedge CLK);
    checks++;
    assert (stall === 1'b0) else begin errors++; $error("FAIL reset_stall: observed %0b expected 0", stall); end
    checks++;
    assert (fwd_sel === 6'd0) else begin errors++; $error("FAIL reset_fwd: observed %0h expected 0", fwd_sel); end
    checks++;
    assert (stall_cnt === 16'd0) else begin errors++; $error("FAIL reset_cnt: observed %0d expected 0", stall_cnt); end
    @(posedge CLK);
    #1;

    // Forwarding window: r5 latency 2.
    step(0, 1, 0, 5, 2, 0, 0, 2'b00);
    repeat (3) step(0, 0, 0, 0, 0, 5, 0, 2'b01);

    // Load-use: r3 latency 4, read back on source 1.
    step(0, 1, 0, 3, 4, 0, 0, 2'b00);
    base = cnt_m;
    repeat (5) step(0, 0, 0, 0, 0, 0, 3, 2'b10);
    checks++;
    assert (stall_cnt === 16'(base + (FWD_ON ? 2 : 4))) else begin
      errors++;
      $error("FAIL load_use_cnt: observed %0d expected %0d", stall_cnt, base + (FWD_ON ? 2 : 4));
    end

    // WAW on r7, then the same issue killed, then a read to observe the surviving count.
    step(0, 1, 0, 7, 5, 0, 0, 2'b00);
    step(0, 1, 0, 7, 1, 0, 0, 2'b00);
    step(0, 1, 1, 7, 1, 0, 0, 2'b00);
    repeat (4) step(0, 0, 0, 0, 0, 7, 7, 2'b11);

    // r0 never becomes pending; an instruction never hazards on its own destination.
    step(0, 1, 0, 0, 3, 0, 0, 2'b00);
    step(0, 0, 0, 0, 0, 0, 0, 2'b11);
    step(0, 1, 0, 9, 3, 9, 9, 2'b11);
    repeat (4) step(0, 0, 0, 0, 0, 9, 0, 2'b01);

    // Unused source bits never stall even when the register is pending.
    step(0, 1, 0, 4, 7, 0, 0, 2'b00);
    step(0, 0, 0, 0, 0, 4, 4, 2'b00);

    // Random traffic over a small register window to provoke frequent hazards.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 11)),
           int'($urandom_range(1, 7)),
           int'($urandom_range(0, 11)),
           int'($urandom_range(0, 11)),
           2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the fixed two-source hazard unit. It tracks in-flight register writes with per-register latency countdowns. From those it decides, for every decode-stage source operand, whether to read the register file, forward from a downstream stage, or stall. It sits beside the decode stage and supports variable-latency producers (ALU, loads, multi-cycle multiply) without per-stage select wiring.

## Interface
Parameters:
- REG_W, 5, register index width; NREGS = 2**REG_W; register 0 is never pending.
- NSRC, 2, number of decode source operands checked per cycle.
- LAT_W, 3, latency counter width; legal issue latency 1..2**LAT_W-1.
- FWD_DEPTH, 2, number of forwarding stages; a result is forwardable when its counter is 1..FWD_DEPTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- issue_valid  in  1  decode instruction is valid and writes a register.
- issue_kill  in  1  squash this cycle's issue (branch flush); no state change from issue.
- issue_wsel  in  REG_W  destination register of decode instruction.
- issue_lat  in  LAT_W  cycles until the result reaches the register file.
- rsel  in  NSRC*REG_W  source registers of decode instruction; source i at [i*REG_W +: REG_W].
- rvalid  in  NSRC  source i is actually used.
- stall  out  1  hold decode; no issue this cycle.
- fwd_sel  out  NSRC*LAT_W  per source: 0 = register file, k (1..FWD_DEPTH) = forward from the stage k cycles before writeback.
- stall_cnt  out  16  saturating count of stalled cycles.

## Operation
- State: pend[r], LAT_W bits per register r, 1..NREGS-1; pend[0] is hard-wired 0.
- Decrement: each cycle, every nonzero pend[r] decrements by 1.
- Issue event: fires when issue_valid & !issue_kill & !stall & issue_wsel != 0. It loads pend[issue_wsel] = issue_lat. The load overrides that register's decrement in the same cycle.
- RAW check, per source i with rvalid[i] and rsel[i] != 0: c = pend[rsel[i]].
  - c == 0: fwd_sel = 0, no stall.
  - With forwarding (see Configuration): 1 <= c <= FWD_DEPTH gives fwd_sel = c; c > FWD_DEPTH stalls.
- Sources with rvalid=0 or register 0 always report fwd_sel = 0 and never stall.
- WAW check: stall when issue_valid & !issue_kill & issue_wsel != 0 & issue_lat <= pend[issue_wsel]. This keeps the older, longer write from landing last.
- stall is the OR of all RAW and WAW conditions. It is asserted even if issue_kill=1 for RAW; issue_kill masks only the WAW term.
- The RAW check always uses pre-issue state. An instruction never hazards on its own destination.
- fwd_sel is valid only when stall=0. When stall=1 it still shows c-clamped values and is don't-care to the datapath.
- stall_cnt increments on every cycle with stall=1 and saturates at 16'hFFFF.
- issue_lat = 0 is illegal. The block treats it as a no-write: pend is unchanged.

## Timing
- stall and fwd_sel are combinational from pend and the current inputs. They settle in the same cycle; there is no added latency.
- pend and stall_cnt are registered and update on the rising CLK edge.
- An issue with latency L at edge t makes pend = L from cycle t+1. Pend reaches 0 at cycle t+1+L-1+1 = t+L+1, where a dependent reads the register file.
- Reset: when RST=1 at an edge, all pend become 0 and stall_cnt becomes 0. Outputs are then stall=0 and fwd_sel=0.
- Reset mid-operation discards all in-flight tracking. RST has priority over issue and decrement in the same cycle.
- Counter wrap: pend never underflows; it saturates at 0.

## Configuration
- HAZARD_FWD_EN defined: forwarding path enabled exactly as described; fwd_sel reports 1..FWD_DEPTH.
- HAZARD_FWD_EN undefined: any c > 0 stalls; fwd_sel is tied to 0. FWD_DEPTH is ignored.

## Test plan
- Reset: hold RST=1 two cycles with issue_valid=1. Required: pend all 0, stall=0, fwd_sel=0, stall_cnt=0.
- Forwarding, HAZARD_FWD_EN: issue r5 lat=2. Next cycle read r5 → stall=1 (c=2? no: c=2 ≤ FWD_DEPTH) → stall=0, fwd_sel=2. Following cycle fwd_sel=1, then 0.
- Load-use: issue r3 lat=4 with FWD_DEPTH=2, then read r3 → stall=1 for 2 cycles, then fwd_sel=2, 1, 0. stall_cnt=2.
- No forwarding, HAZARD_FWD_EN off: same r3 lat=4 sequence → stall=1 for 4 cycles, then fwd_sel=0.
- WAW and kill: pend[r7]=5, issue r7 lat=1 → stall=1. Same with issue_kill=1 → stall=0 and pend[r7] unchanged (decrements to 4).
- r0 and self-dependence: issue r0 lat=3 → no pend change. Issue r9 lat=3 with rsel=r9 in the same cycle → stall=0, fwd_sel=0.
